// File: rtl/music_pkg.sv
// rtl/music_pkg.sv - shared widths, default sizing and FSM encoding for the music recorder
package music_pkg;

  localparam int FREQ_W        = 32;
  localparam int DEF_MEM_DEPTH = 1000;
  localparam int DEF_ADDR_W    = 10;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RECORD = 2'd1;
  localparam logic [1:0] ST_PLAY   = 2'd2;

  // A zero beat period would never tick; run it as one cycle per beat instead.
  function automatic logic [31:0] eff_period(input logic [31:0] period);
    return (period == 32'd0) ? 32'd1 : period;
  endfunction

endpackage

// File: rtl/beat_tick_gen.sv
// rtl/beat_tick_gen.sv - beat counter producing a one-cycle tick every beat_period cycles
module beat_tick_gen
  import music_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        pause,
  input  logic [31:0] beat_period,
  output logic        tick
);

  logic [31:0] count;

  // >= rather than == so a period shortened mid-beat still ticks promptly.
  assign tick = !clear && !pause && (count >= eff_period(beat_period) - 32'd1);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (tick) begin
      count <= '0;
    end else if (!pause) begin
      count <= count + 32'd1;
    end
  end

endmodule

// File: rtl/music_recorder.sv
// rtl/music_recorder.sv - beat-quantised note recorder/player; MUSIC_REC_LOOP_EN makes playback loop
module music_recorder
  import music_pkg::*;
#(
  parameter int MEM_DEPTH = DEF_MEM_DEPTH,
  parameter int ADDR_W    = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rec_en,
  input  logic              play_en,
  input  logic              pause,
  input  logic [FREQ_W-1:0] live_freq,
  input  logic [31:0]       beat_period,
  output logic [FREQ_W-1:0] box_freq,
  output logic [ADDR_W-1:0] rec_len,
  output logic              recording,
  output logic              playing,
  output logic              full
);

  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);
  localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);

  logic [1:0]        state;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic [IDX_W-1:0]  wr_idx;
  logic [IDX_W-1:0]  rd_idx;
  logic              rec_hold;
  logic              play_hold;
  logic              tick;
  logic              clear;
  logic              start_rec;
  logic              start_play;
  logic              wr_en;
  logic              last_note;
  logic [FREQ_W-1:0] mem [MEM_DEPTH];

  // The hold flags stop a still-held enable from restarting a take that just ended.
  assign start_rec  = (state == ST_IDLE) && rec_en && !rec_hold;
  assign start_play = (state == ST_IDLE) && !rec_en && play_en && !play_hold
                      && (rec_len != '0);
  assign clear      = start_rec || start_play;
  assign wr_en      = (state == ST_RECORD) && rec_en && tick;
  assign last_note  = (rd_addr == rec_len - ONE);
  assign wr_idx     = wr_addr[IDX_W-1:0];
  assign rd_idx     = rd_addr[IDX_W-1:0];
  assign recording  = (state == ST_RECORD);
  assign playing    = (state == ST_PLAY);

  beat_tick_gen u_beat (
    .clk         (clk),
    .reset       (reset),
    .clear       (clear),
    .pause       (pause),
    .beat_period (beat_period),
    .tick        (tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      wr_addr   <= '0;
      rd_addr   <= '0;
      rec_len   <= '0;
      full      <= 1'b0;
      rec_hold  <= 1'b0;
      play_hold <= 1'b0;
    end else begin
      if (!rec_en) begin
        rec_hold <= 1'b0;
      end
      if (!play_en) begin
        play_hold <= 1'b0;
      end
      case (state)
        ST_IDLE: begin
          if (start_rec) begin
            state   <= ST_RECORD;
            wr_addr <= '0;
            rec_len <= '0;
            full    <= 1'b0;
          end else if (start_play) begin
            state   <= ST_PLAY;
            rd_addr <= '0;
          end
        end
        ST_RECORD: begin
          if (!rec_en) begin
            state <= ST_IDLE;
          end else if (tick) begin
            wr_addr <= wr_addr + ONE;
            rec_len <= wr_addr + ONE;
            if (wr_addr == LAST_ADDR) begin
              full     <= 1'b1;
              rec_hold <= 1'b1;
              state    <= ST_IDLE;
            end
          end
        end
        ST_PLAY: begin
          if (!play_en) begin
            state <= ST_IDLE;
          end else if (tick) begin
            if (last_note) begin
`ifdef MUSIC_REC_LOOP_EN
              rd_addr <= '0;
`else
              state     <= ST_IDLE;
              play_hold <= 1'b1;
`endif
            end else begin
              rd_addr <= rd_addr + ONE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= live_freq;
    end
  end

  // box_freq doubles as the memory's synchronous read register during PLAY.
  always_ff @(posedge clk) begin
    if (reset || pause) begin
      box_freq <= '0;
    end else if (state == ST_RECORD) begin
      box_freq <= live_freq;
    end else if (state == ST_PLAY) begin
      box_freq <= mem[rd_idx];
    end else begin
      box_freq <= '0;
    end
  end

endmodule

// File: tb/tb_music_recorder.sv
// tb/tb_music_recorder.sv - randomized self-checking bench for music_recorder against a note-list model
module tb_music_recorder;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        rec_en;
  logic        play_en;
  logic        pause;
  logic [31:0] live_freq;
  logic [31:0] beat_period;
  logic [31:0] box_freq;
  logic [3:0]  rec_len;
  logic        recording;
  logic        playing;
  logic        full;

  int total = 0;
  int bad   = 0;
  int exp_mem[$];

  always #5 clk = ~clk;

  music_recorder #(.MEM_DEPTH(DEPTH), .ADDR_W(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .rec_en      (rec_en),
    .play_en     (play_en),
    .pause       (pause),
    .live_freq   (live_freq),
    .beat_period (beat_period),
    .box_freq    (box_freq),
    .rec_len     (rec_len),
    .recording   (recording),
    .playing     (playing),
    .full        (full)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; rec_en = 1'b0; play_en = 1'b0; pause = 1'b0;
    live_freq = 32'd0; beat_period = 32'd4;
    cyc(); cyc();
    reset = 1'b0;
    cyc();
    total++;
    if (box_freq !== 32'd0 || rec_len !== 4'd0 || full !== 1'b0 || recording !== 1'b0 || playing !== 1'b0) begin
      bad++;
      $display("FAIL reset_state got box=%0d len=%0d full=%b rec=%b play=%b exp all 0",
               box_freq, rec_len, full, recording, playing);
    end
    play_en = 1'b1;
    cyc(); cyc();
    total++;
    if (playing !== 1'b0 || box_freq !== 32'd0) begin
      bad++;
      $display("FAIL empty_play got play=%b box=%0d exp play=0 box=0", playing, box_freq);
    end
    play_en = 1'b0;
    cyc();
  endtask

  // Model: note k is whatever live_freq holds during beat k of the take.
  task automatic test_record(input int notes[$], input int p);
    int ep = (p == 0) ? 1 : p;
    exp_mem.delete();
    beat_period = p;
    live_freq   = notes[0];
    rec_en      = 1'b1;
    cyc();
    total++;
    if (recording !== 1'b1) begin
      bad++;
      $display("FAIL rec_enter got recording=%b exp 1", recording);
    end
    for (int k = 0; k < notes.size(); k++) begin
      live_freq = notes[k];
      exp_mem.push_back(notes[k]);
      repeat (ep) cyc();
      total++;
      if (box_freq !== notes[k]) begin
        bad++;
        $display("FAIL rec_monitor beat %0d got box=%0d exp %0d", k, box_freq, notes[k]);
      end
    end
    rec_en = 1'b0;
    cyc();
    total++;
    if (recording !== 1'b0 || rec_len !== 4'(notes.size()) || full !== 1'b0) begin
      bad++;
      $display("FAIL rec_done got recording=%b len=%0d full=%b exp 0 %0d 0",
               recording, rec_len, full, notes.size());
    end
  endtask

  // Model: playback shows each recorded note for exactly one beat of unpaused cycles.
  task automatic test_play(input int p, input int pause_at);
    int ep   = (p == 0) ? 1 : p;
    int n    = exp_mem.size();
    int span = n * ep;
    bit loop_mode = 1'b0;
    bit exp_play;
`ifdef MUSIC_REC_LOOP_EN
    loop_mode = 1'b1;
    span = (n + 1) * ep;
`endif
    beat_period = p;
    play_en = 1'b1;
    cyc();
    for (int v = 0; v < span; v++) begin
      if (v == pause_at) begin
        pause = 1'b1;
        for (int i = 0; i < 10; i++) begin
          cyc();
          total++;
          if (box_freq !== 32'd0 || playing !== 1'b1) begin
            bad++;
            $display("FAIL pause_hold cycle %0d got box=%0d play=%b exp 0 1", i, box_freq, playing);
          end
        end
        pause = 1'b0;
      end
      cyc();
      exp_play = loop_mode || (v < span - 1);
      total++;
      if (box_freq !== exp_mem[(v / ep) % n] || playing !== exp_play) begin
        bad++;
        $display("FAIL play_note slot %0d got box=%0d play=%b exp %0d %b",
                 v, box_freq, playing, exp_mem[(v / ep) % n], exp_play);
      end
    end
    if (loop_mode) begin
      play_en = 1'b0;
      cyc(); cyc();
    end else begin
      cyc(); cyc(); cyc();
    end
    total++;
    if (box_freq !== 32'd0 || playing !== 1'b0) begin
      bad++;
      $display("FAIL play_end got box=%0d play=%b exp 0 0", box_freq, playing);
    end
    play_en = 1'b0;
    cyc();
  endtask

  task automatic test_full();
    beat_period = 32'd1;
    live_freq   = $urandom_range(1, 20000);
    rec_en      = 1'b1;
    exp_mem.delete();
    cyc();
    for (int k = 0; k < DEPTH; k++) begin
      live_freq = $urandom_range(1, 20000);
      exp_mem.push_back(int'(live_freq));
      cyc();
      if (k < DEPTH - 1) begin
        total++;
        if (recording !== 1'b1 || full !== 1'b0) begin
          bad++;
          $display("FAIL full_early write %0d got rec=%b full=%b exp 1 0", k, recording, full);
        end
      end
    end
    total++;
    if (full !== 1'b1 || rec_len !== 4'(DEPTH) || recording !== 1'b0) begin
      bad++;
      $display("FAIL full_set got full=%b len=%0d rec=%b exp 1 %0d 0", full, rec_len, recording, DEPTH);
    end
    cyc(); cyc();
    total++;
    if (full !== 1'b1 || recording !== 1'b0) begin
      bad++;
      $display("FAIL full_stay got full=%b rec=%b exp 1 0", full, recording);
    end
    rec_en = 1'b0;
    cyc();
    test_play(1, -1);
  endtask

  task automatic test_priority();
    beat_period = 32'd50;
    rec_en  = 1'b1;
    play_en = 1'b1;
    cyc();
    total++;
    if (recording !== 1'b1 || playing !== 1'b0 || rec_len !== 4'd0 || full !== 1'b0) begin
      bad++;
      $display("FAIL both_rise got rec=%b play=%b len=%0d full=%b exp 1 0 0 0",
               recording, playing, rec_len, full);
    end
    cyc(); cyc();
    total++;
    if (playing !== 1'b0) begin
      bad++;
      $display("FAIL play_in_rec got play=%b exp 0", playing);
    end
    rec_en = 1'b0;
    cyc(); cyc();
    total++;
    if (recording !== 1'b0 || playing !== 1'b0 || rec_len !== 4'd0) begin
      bad++;
      $display("FAIL empty_take got rec=%b play=%b len=%0d exp 0 0 0", recording, playing, rec_len);
    end
    play_en = 1'b0;
    cyc();
  endtask

  task automatic test_reset_mid();
    int notes[$];
    for (int k = 0; k < 3; k++) notes.push_back($urandom_range(1, 20000));
    test_record(notes, 3);
    play_en = 1'b1;
    repeat (5) cyc();
    reset = 1'b1;
    cyc();
    total++;
    if (box_freq !== 32'd0 || rec_len !== 4'd0 || playing !== 1'b0) begin
      bad++;
      $display("FAIL reset_play got box=%0d len=%0d play=%b exp 0 0 0", box_freq, rec_len, playing);
    end
    reset = 1'b0; play_en = 1'b0;
    cyc();
    rec_en = 1'b1;
    repeat (3) cyc();
    reset = 1'b1;
    cyc();
    total++;
    if (recording !== 1'b0 || box_freq !== 32'd0) begin
      bad++;
      $display("FAIL reset_rec got rec=%b box=%0d exp 0 0", recording, box_freq);
    end
    reset = 1'b0; rec_en = 1'b0;
    cyc();
  endtask

  task automatic test_random();
    for (int it = 0; it < 5; it++) begin
      int notes[$];
      int n  = $urandom_range(1, DEPTH - 1);
      int p  = $urandom_range(0, 4);
      int ep = (p == 0) ? 1 : p;
      int pa = (n * ep >= 2) ? int'($urandom_range(0, n * ep - 2)) : -1;
      for (int k = 0; k < n; k++) notes.push_back($urandom_range(0, 20000));
      test_record(notes, p);
      test_play(p, pa);
    end
  endtask

  initial begin
    int fixed[$];
    test_reset();
    fixed = '{262, 294, 330};
    test_record(fixed, 4);
    test_play(4, -1);
    test_play(4, 6);
    test_full();
    test_priority();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
